// File: rtl/bp_pkg.sv
// Shared types, table geometry and field-extraction helpers for the branch predictor.
package bp_pkg;

  localparam int unsigned BP_ENTRIES       = 64;
  localparam int unsigned BP_COUNTER_WIDTH = 2;
  localparam int unsigned BP_XLEN          = 32;
  localparam int unsigned BP_INDEX_BITS    = $clog2(BP_ENTRIES);
  // Bits above the index; pc[1:0] never take part in lookup.
  localparam int unsigned BP_TAG_WIDTH     = BP_XLEN - BP_INDEX_BITS - 2;

  typedef struct packed {
    logic                        valid;
    logic [BP_TAG_WIDTH-1:0]     tag;
    logic [BP_COUNTER_WIDTH-1:0] counter;
    logic [BP_XLEN-1:0]          target;
  } bht_entry_t;

  // Weakly-not-taken: just below the counter midpoint.
  function automatic int unsigned weak_nt(int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Weakly-taken: the counter midpoint (MSB set, rest clear).
  function automatic int unsigned weak_t(int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // Table index = pc[index_bits+1:2], returned zero-extended.
  function automatic logic [BP_XLEN-1:0] bp_index(logic [BP_XLEN-1:0] pc,
                                                  int unsigned index_bits);
    logic [BP_XLEN-1:0] mask;
    mask = (BP_XLEN'(1) << index_bits) - BP_XLEN'(1);
    return (pc >> 2) & mask;
  endfunction

  // Tag = pc[XLEN-1:index_bits+2], returned zero-extended.
  function automatic logic [BP_XLEN-1:0] bp_tag(logic [BP_XLEN-1:0] pc,
                                                int unsigned index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Next-state of a saturating up/down counter; holds when both or neither direction is asked.
module sat_counter_next #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Step one position toward the requested end, clamping at the rails.
  always_comb begin
    next = count;
    if (up && !down && count != MAX_VAL) begin
      next = count + WIDTH'(1);
    end else if (down && !up && count != '0) begin
      next = count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with integrated target buffer.
// Lookup is combinational off fetch_pc; the execute stage trains it one branch per cycle.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES       = BP_ENTRIES,
  parameter int unsigned COUNTER_WIDTH = BP_COUNTER_WIDTH,
  parameter int unsigned XLEN          = BP_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            flush
);

  localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_WIDTH  = XLEN - INDEX_BITS - 2;

  localparam logic [COUNTER_WIDTH-1:0] WEAK_NT = COUNTER_WIDTH'(weak_nt(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] WEAK_T  = COUNTER_WIDTH'(weak_t(COUNTER_WIDTH));

  localparam bht_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, counter: WEAK_NT, target: '0};

  // The entry layout is shared through the package, so the geometry must agree with it.
  if (XLEN != BP_XLEN || COUNTER_WIDTH != BP_COUNTER_WIDTH || TAG_WIDTH != BP_TAG_WIDTH)
  begin : g_param_check
    $error("branch_predictor_bht parameters disagree with bp_pkg entry layout");
  end

  bht_entry_t table_q [ENTRIES];

  logic [INDEX_BITS-1:0]    fetch_idx;
  logic [TAG_WIDTH-1:0]     fetch_tag;
  bht_entry_t               fetch_entry;
  logic [INDEX_BITS-1:0]    upd_idx;
  logic [TAG_WIDTH-1:0]     upd_tag;
  bht_entry_t               upd_entry;
  logic                     upd_hit;
  logic [COUNTER_WIDTH-1:0] upd_counter_next;
  bht_entry_t               upd_entry_d;

  assign fetch_idx   = INDEX_BITS'(bp_index(fetch_pc, INDEX_BITS));
  assign fetch_tag   = TAG_WIDTH'(bp_tag(fetch_pc, INDEX_BITS));
  assign fetch_entry = table_q[fetch_idx];

  assign upd_idx   = INDEX_BITS'(bp_index(update_pc, INDEX_BITS));
  assign upd_tag   = TAG_WIDTH'(bp_tag(update_pc, INDEX_BITS));
  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  // Prediction reads registered state only, so a same-index update shows up next cycle.
  always_comb begin
    predict_hit    = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    predict_taken  = predict_hit && fetch_entry.counter[COUNTER_WIDTH-1];
    predict_target = predict_taken ? fetch_entry.target : fetch_pc + XLEN'(32'd4);
  end

  sat_counter_next #(
    .WIDTH(COUNTER_WIDTH)
  ) u_update_counter (
    .count(upd_entry.counter),
    .up   (update_taken),
    .down (~update_taken),
    .next (upd_counter_next)
  );

  // Build the replacement entry: train on a hit, allocate fresh on a miss or alias.
  always_comb begin
    upd_entry_d = upd_entry;
    if (upd_hit) begin
      upd_entry_d.counter = upd_counter_next;
      if (update_taken) begin
        upd_entry_d.target = update_target;
      end
    end else begin
      upd_entry_d.valid   = 1'b1;
      upd_entry_d.tag     = upd_tag;
      upd_entry_d.counter = update_taken ? WEAK_T : WEAK_NT;
      upd_entry_d.target  = update_target;
    end
  end

  // Table storage; flush drops any same-cycle update and leaves counters/targets alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= RESET_ENTRY;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (update_valid) begin
      table_q[upd_idx] <= upd_entry_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench: directed vector table, hand-written reset sequence, random vs model.
module tb_branch_predictor_bht;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned CW      = 2;
  localparam int unsigned XLEN    = 32;
  localparam int          HALF    = 1 << (CW - 1);
  localparam int          CMAX    = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] fetch_pc;
  logic            predict_hit;
  logic            predict_taken;
  logic [XLEN-1:0] predict_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            flush;

  always #5 clk = ~clk;

  branch_predictor_bht #(
    .ENTRIES      (ENTRIES),
    .COUNTER_WIDTH(CW),
    .XLEN         (XLEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_pc      (fetch_pc),
    .predict_hit   (predict_hit),
    .predict_taken (predict_taken),
    .predict_target(predict_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .flush         (flush)
  );

  typedef struct {
    logic [31:0] fetch;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    bit          fl;
    bit          hit;
    bit          tk;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: one record per table slot, counters as plain integers.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] f, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit fl);
    fetch_pc      = f;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    flush         = fl;
  endtask

  task automatic check_pred(input string name, input bit hit, input bit tk,
                            input logic [31:0] tgt);
    check({name, "_hit"}, 32'(predict_hit), 32'(hit));
    check({name, "_taken"}, 32'(predict_taken), 32'(tk));
    check({name, "_target"}, predict_target, tgt);
  endtask

  function automatic void add(input logic [31:0] f, input bit uv, input logic [31:0] upc,
                              input bit ut, input logic [31:0] utgt, input bit fl,
                              input bit hit, input bit tk, input logic [31:0] tgt);
    vec_t v;
    v = '{fetch: f, uv: uv, upc: upc, ut: ut, utgt: utgt, fl: fl, hit: hit, tk: tk, tgt: tgt};
    vecs.push_back(v);
  endfunction

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = HALF - 1;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit hit, output bit tk,
                                        output logic [31:0] tgt);
    int i;
    i   = m_index(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_ctr[i] >= HALF);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_clock(input bit uv, input logic [31:0] upc, input bit ut,
                                      input logic [31:0] utgt, input bit fl);
    int i;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      return;
    end
    if (!uv) return;
    i = m_index(upc);
    if (m_valid[i] && m_tag[i] == m_tagof(upc)) begin
      if (ut) begin
        m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
        m_tgt[i] = utgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else begin
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(upc);
      m_ctr[i]   = ut ? HALF : HALF - 1;
      m_tgt[i]   = utgt;
    end
  endfunction

  logic [31:0] tag_pool [4];

  initial begin
    bit          e_hit, e_tk;
    logic [31:0] e_tgt;

    // Expected outputs are the prediction seen during that cycle, before its update lands.
    add(32'h100, 0, 0, 0, 0, 0,              0, 0, 32'h104);      // cold
    add(32'h100, 1, 32'h100, 1, 32'h80, 0,   0, 0, 32'h104);      // allocate WEAK_T
    add(32'h100, 0, 0, 0, 0, 0,              1, 1, 32'h80);
    add(32'h104, 0, 0, 0, 0, 0,              0, 0, 32'h108);
    add(32'h100, 1, 32'h100, 0, 32'h444, 0,  1, 1, 32'h80);       // 10 -> 01
    add(32'h100, 1, 32'h100, 0, 32'h444, 0,  1, 0, 32'h104);      // 01 -> 00
    add(32'h100, 1, 32'h100, 0, 32'h444, 0,  1, 0, 32'h104);      // 00 -> 00
    add(32'h100, 1, 32'h100, 1, 32'h80, 0,   1, 0, 32'h104);      // 00 -> 01
    add(32'h100, 1, 32'h100, 1, 32'h80, 0,   1, 0, 32'h104);      // 01 -> 10, same-cycle
    add(32'h100, 1, 32'h100, 1, 32'h88, 0,   1, 1, 32'h80);       // 10 -> 11
    add(32'h100, 1, 32'h100, 1, 32'h88, 0,   1, 1, 32'h88);       // 11 -> 11
    add(32'h100, 1, 32'h100, 0, 32'h444, 0,  1, 1, 32'h88);       // 11 -> 10
    add(32'h100, 0, 0, 0, 0, 0,              1, 1, 32'h88);
    add(32'h200, 1, 32'h200, 0, 32'h300, 0,  0, 0, 32'h204);      // alias replaces
    add(32'h200, 0, 0, 0, 0, 0,              1, 0, 32'h204);
    add(32'h100, 0, 0, 0, 0, 0,              0, 0, 32'h104);
    add(32'hFFFFFFFC, 0, 0, 0, 0, 0,         0, 0, 32'h0);        // wrap
    add(32'h200, 1, 32'h104, 1, 32'h500, 1,  1, 0, 32'h204);      // flush beats update
    add(32'h200, 0, 0, 0, 0, 0,              0, 0, 32'h204);
    add(32'h104, 0, 0, 0, 0, 0,              0, 0, 32'h108);
    add(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'h40, 0, 0, 0, 32'h0);
    add(32'hFFFFFFFC, 0, 0, 0, 0, 0,         1, 1, 32'h40);
    add(32'hFFFFFFFD, 0, 0, 0, 0, 0,         1, 1, 32'h40);       // pc[1:0] ignored

    drive(32'h100, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12;
    check_pred("in_reset", 0, 0, 32'h104);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fetch, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].fl);
      #1;
      check_pred($sformatf("vec%0d", i), vecs[i].hit, vecs[i].tk, vecs[i].tgt);
    end

    // Asynchronous reset mid-cycle, held across an edge with an update pending.
    @(negedge clk);
    drive(32'hFFFFFFFC, 0, 0, 0, 0, 0);
    #1;
    check_pred("pre_reset", 1, 1, 32'h40);
    #1;
    reset = 1'b1;
    #1;
    check_pred("async_reset", 0, 0, 32'h0);
    drive(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'h60, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(32'hFFFFFFFC, 0, 0, 0, 0, 0);
    #1;
    check_pred("post_reset", 0, 0, 32'h0);
    @(negedge clk);
    #1;
    check_pred("post_reset2", 0, 0, 32'h0);

    // Random training against the model; small pc pool so aliasing and hits are common.
    model_reset();
    tag_pool[0] = 32'h0;
    tag_pool[1] = 32'h1;
    tag_pool[2] = 32'hABCDE;
    tag_pool[3] = 32'hFFFFFF;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] f, upc, utgt;
      bit          uv, ut, fl;
      f    = (tag_pool[$urandom_range(3)] << 8) | ($urandom_range(7) << 2) | $urandom_range(3);
      upc  = (tag_pool[$urandom_range(3)] << 8) | ($urandom_range(7) << 2) | $urandom_range(3);
      utgt = $urandom & 32'hFFFFFFFC;
      uv   = ($urandom_range(9) < 7);
      ut   = $urandom_range(1) == 1;
      fl   = ($urandom_range(24) == 0);
      @(negedge clk);
      drive(f, uv, upc, ut, utgt, fl);
      #1;
      model_predict(f, e_hit, e_tk, e_tgt);
      check_pred($sformatf("rand%0d", n), e_hit, e_tk, e_tgt);
      model_clock(uv, upc, ut, utgt, fl);
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Direct-mapped branch history table (BHT) with an integrated branch target buffer, indexed by fetch PC. Sits directly upstream of the fetch PC-select mux: each cycle it supplies a taken prediction and next-PC target for the current fetch PC. The execute stage updates it when a branch resolves. Each entry holds an n-bit saturating direction counter, a tag and a target.

Parameters:
ENTRIES, 64, number of table entries; power of 2, >= 2
COUNTER_WIDTH, 2, saturating direction counter width; >= 1
XLEN, 32, PC/target width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high; clears all entries
fetch_pc  input  XLEN  PC being fetched this cycle
predict_hit  output  1  valid entry with matching tag for fetch_pc
predict_taken  output  1  predicted direction
predict_target  output  XLEN  predicted next PC
update_valid  input  1  resolved branch this cycle
update_pc  input  XLEN  PC of resolved branch
update_taken  input  1  actual direction
update_target  input  XLEN  actual taken target
flush  input  1  synchronous invalidate of all entries

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. Reset clears all valid bits and sets counters to WEAK_NT = 2^(COUNTER_WIDTH-1)-1 (01 for width 2). Tags and targets are don't-care.
- Output values during and after reset (outputs are combinational): predict_hit=0, predict_taken=0, predict_target=fetch_pc+4.
- Index = pc[INDEX_BITS+1:2], where INDEX_BITS=log2(ENTRIES). Tag = pc[XLEN-1:INDEX_BITS+2]. pc[1:0] is ignored.
- Prediction path (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==fetch tag.
  - predict_taken = hit && counter[idx][MSB].
  - predict_target = predict_taken ? target[idx] : fetch_pc+4, with XLEN wrap-around (0xFFFFFFFC+4 = 0).
- Update path (at posedge clk when update_valid=1 and reset=0):
  - On an update hit:
    - update_taken=1: counter increments, saturating at 2^COUNTER_WIDTH-1.
    - update_taken=0: counter decrements, saturating at 0.
    - Target is overwritten with update_target only when update_taken=1.
  - On an update miss (invalid entry, or tag mismatch / alias): allocate and replace.
    - valid=1, tag written.
    - Counter = update_taken ? WEAK_T (2^(COUNTER_WIDTH-1)) : WEAK_NT.
    - target = update_target.
- Read-during-write to the same index: prediction that cycle uses the pre-update contents. The new contents are visible from the next cycle. No bypass.
- Flush: flush=1 clears all valid bits at the posedge. Counters and targets are unchanged.
- Flush and update_valid in the same cycle: flush wins, so the update is dropped.
- Reset asserted mid-update: reset wins immediately (asynchronous); no partial writes.
- No stall input: the table holds state whenever update_valid=0.

Decomposition:
- Package bp_pkg:
  - bht_entry_t struct {valid, tag, counter, target}, parameterised via localparams.
  - WEAK_NT and WEAK_T constant functions of COUNTER_WIDTH.
  - index/tag extraction functions.
- Sub-module sat_counter_next: combinational next-state of a COUNTER_WIDTH saturating counter (inputs count, up, down; output next). One instance serves the update port.
- The entry array lives in branch_predictor_bht as an always_ff array with asynchronous reset.

Test Plan:
1. Cold start: reset, then fetch_pc=0x100 -> predict_hit=0, predict_taken=0, predict_target=0x104.
2. Allocate: update pc=0x100, taken=1, target=0x80 -> next cycle fetch 0x100 gives hit=1, counter=10, taken=1, target=0x80. fetch 0x104 gives hit=0, target=0x108.
3. Saturation:
   - From counter=10, three not-taken updates give 01, 00, 00 -> taken=0, target=0x104.
   - Then four taken updates give 01, 10, 11, 11 -> taken=1 after the 2nd.
   - Target is unchanged by not-taken updates.
4. Alias: entry at 0x100 exists; update pc=0x200 (same index 0, tag differs), taken=0 -> fetch 0x200 gives hit=1, taken=0; fetch 0x100 gives hit=0.
5. Same-cycle read/write: fetch_pc=update_pc=0x100 with counter 01 and update taken=1 -> that cycle taken=0; next cycle counter=10, taken=1.
6. Flush/reset:
   - flush together with update_valid -> all fetches miss next cycle and the update is dropped.
   - Asynchronous reset pulse mid-cycle -> predict_hit=0 immediately, and stays 0 after release.
